core_alu_issue: RTL and testbench
=================================

Name: core_alu_issue

Overview:
- Issue/writeback sequencer for TOY arithmetic-class instructions, one instruction at a time.
- Accepts a 16-bit instruction over a valid/ready handshake and reads the source registers from its local 16x16 register file.
- Drives the ALU's operation/operand inputs and captures the ALU result one cycle later, writing it back to R[d].
- Sits between fetch and core_alu; it is the producer side of the ALU's op/a/b interface.

Parameters:
- ALU_LAT, 1, cycles from operands presented to result valid on alu_c_i; fixed at 1 to match core_alu's input registering.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  issuer can accept an instruction
- instr_i  in  16  TOY instruction: [15:12] opcode, [11:8] d, [7:4] s, [3:0] t, [7:0] addr
- alu_op_o  out  3  ALU operation select
- alu_a_o  out  16  ALU operand a
- alu_b_o  out  16  ALU operand b
- alu_c_i  in  16  ALU result
- done_o  out  1  one-cycle pulse: instruction retired
- illegal_o  out  1  one-cycle pulse with done_o: opcode not handled here
- halted_o  out  1  level: halt instruction retired
- dbg_addr_i  in  4  debug register read address
- dbg_data_o  out  16  R[dbg_addr_i], combinational

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; all R[i]=0.
  - alu_op_o=0, alu_a_o=0, alu_b_o=0, done_o=0, illegal_o=0, halted_o=0, instr_ready_o=0 while reset is asserted.
  - First cycle after deassertion: instr_ready_o=1.
- Reset mid-operation: aborts the instruction, no writeback, no done_o.
- FSM states: IDLE, ISSUE, WB, HALT.
  - instr_ready_o=1 only in IDLE; accept = instr_valid_i & instr_ready_o.
- IDLE, on accept, by opcode:
  - Opcode 1..7: latch d; register alu_op_o/a/b from the combinational regfile read; go to ISSUE.
  - Opcode 0 (halt): go to HALT; done_o=1 next cycle; halted_o=1 from next cycle onward.
  - Opcode 8..F: done_o=1 and illegal_o=1 next cycle; no register write; state stays IDLE; instr_ready_o=0 for that one cycle.
- Opcode mapping to ALU:
  - 1 add: op=0, a=R[s], b=R[t]
  - 2 sub: op=1, a=R[s], b=R[t]
  - 3 and: op=2, a=R[s], b=R[t]
  - 4 xor: op=3, a=R[s], b=R[t]
  - 5 shl: op=4, a=R[s], b=R[t]
  - 6 shr: op=5, a=R[s], b=R[t]
  - 7 lda: op=7, a=0, b={8'h00,addr}
- ISSUE: outputs hold their values (the ALU captures them at the end of this cycle); go to WB.
- WB: R[d] <= alu_c_i at the end of the cycle; done_o=1; go to IDLE.
- Timing: accept at cycle N -> ISSUE N+1 -> WB/done N+2 -> ready again N+3. Throughput is one instruction per 3 cycles.
- alu_* outputs hold their last value outside ISSUE.
- R0:
  - Reads always return 0.
  - A write to d=0 is discarded but still retires with done_o.
- Hazards: none; a writeback completes before the next accept, so back-to-back dependent instructions see the new value.
- Arithmetic: 16-bit wrap-around, performed by the ALU; no flags.
- HALT: absorbing state; instr_ready_o=0 and halted_o=1 until reset.
- dbg_data_o reflects a WB write starting the cycle after the write.

Decomposition:
- core_pkg holds:
  - alu_op_t enum (ADD=0, SUB, AND, XOR, SHL, SHR, PASSA, PASSB)
  - toy_opcode_t enum (HLT=0 .. JL=F)
  - issue_state_t enum
  - instruction field-slice constants
- Sub-module core_regfile:
  - 16x16 storage
  - two combinational read ports plus a debug read port
  - one synchronous write port
  - R0 forced to zero
  - async active-high reset clears all entries

Test Plan:
- Reset, then lda R1=0x05 (7105) -> done_o at accept+2, dbg R1=0x0005; then lda R2=0xFF (72FF) -> R2=0x00FF.
- add R3=R1+R2 (1312) issued immediately after the R2 write -> alu_op_o=0, a=0x0005, b=0x00FF in ISSUE; R3=0x0104.
- sub R4=R1-R2 (2412) -> R4=0xFF06 (wrap). shl R5=R1<<R1 (6511 uses shr; use 5511) -> R5=0x00A0.
- Write to R0 (7012) -> done_o pulses, dbg R0=0x0000. Opcode 8 (8123) -> done_o and illegal_o pulse, no register changes, ready returns the following cycle.
- Halt (0000) -> halted_o=1 from accept+1, instr_ready_o stuck at 0 for 20 cycles with instr_valid_i=1.
- Assert rst_i asynchronously during ISSUE of 1312 -> outputs go to 0 immediately, no done_o, R3 reads 0 after reset.

Source files
------------

// File: rtl/core_alu_issue_pkg.sv
// Shared types and constants for the TOY ALU issue/writeback slice.
package core_pkg;

  localparam int REG_W = 16;
  localparam int REG_N = 16;

  // Instruction field positions: [15:12] opcode, [11:8] d, [7:4] s, [3:0] t, [7:0] addr
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 4;
  localparam int RT_MSB   = 3;
  localparam int RT_LSB   = 0;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_XOR   = 3'd3,
    ALU_SHL   = 3'd4,
    ALU_SHR   = 3'd5,
    ALU_PASSA = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  typedef enum logic [3:0] {
    OP_HLT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_LDA = 4'h7,
    OP_LD  = 4'h8, OP_ST  = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
    OP_BZ  = 4'hC, OP_BP  = 4'hD, OP_JR  = 4'hE, OP_JL  = 4'hF
  } toy_opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } issue_state_t;

  // ALU operation for each arithmetic-class opcode; lda passes operand b through.
  function automatic alu_op_t alu_op_for(input toy_opcode_t opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_PASSB;
    endcase
  endfunction

endpackage

// File: rtl/core_alu_issue_if.sv
// Instruction handshake plus the ALU operand/result bus seen by the issuer.
interface core_alu_issue_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [15:0] instr_i;
  logic [2:0]  alu_op_o;
  logic [15:0] alu_a_o;
  logic [15:0] alu_b_o;
  logic [15:0] alu_c_i;

  // Issue unit side
  modport slave (
    input  instr_valid_i, instr_i, alu_c_i,
    output instr_ready_o, alu_op_o, alu_a_o, alu_b_o
  );

  // Fetch / ALU environment side
  modport master (
    output instr_valid_i, instr_i, alu_c_i,
    input  instr_ready_o, alu_op_o, alu_a_o, alu_b_o
  );
endinterface

// File: rtl/core_alu_issue_regfile.sv
// 16x16 register file: two combinational read ports, a debug read port,
// one synchronous write port; R0 always reads zero.
module core_regfile
  import core_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       ra_addr_i,
  input  logic [3:0]       rb_addr_i,
  input  logic [3:0]       dbg_addr_i,
  output logic [REG_W-1:0] ra_data_o,
  output logic [REG_W-1:0] rb_data_o,
  output logic [REG_W-1:0] dbg_data_o,
  input  logic             we_i,
  input  logic [3:0]       wr_addr_i,
  input  logic [REG_W-1:0] wr_data_i
);

  logic [REG_W-1:0] regs_q [REG_N];
  logic [REG_W-1:0] regs_d [REG_N];

  // Next-state of the array; writes to R0 are dropped so it stays zero.
  always_comb begin
    for (int i = 0; i < REG_N; i++) regs_d[i] = regs_q[i];
    if (we_i && (wr_addr_i != 4'd0)) regs_d[wr_addr_i] = wr_data_i;
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data_o  = (ra_addr_i  == 4'd0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o  = (rb_addr_i  == 4'd0) ? '0 : regs_q[rb_addr_i];
  assign dbg_data_o = (dbg_addr_i == 4'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/core_alu_issue.sv
// Issue/writeback sequencer: accepts one TOY arithmetic instruction at a time,
// presents operands to the ALU, and writes the result back one cycle later.
module core_alu_issue
  import core_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  core_alu_issue_if.slave      io,
  output logic                 done_o,
  output logic                 illegal_o,
  output logic                 halted_o,
  input  logic [3:0]           dbg_addr_i,
  output logic [REG_W-1:0]     dbg_data_o
);

  // The ISSUE/WB sequence assumes the ALU registers its inputs exactly once.
  if (ALU_LAT != 1) begin : g_bad_lat
    $error("core_alu_issue supports only ALU_LAT == 1");
  end

  issue_state_t     state_q, state_d;
  logic [3:0]       rd_q, rd_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [REG_W-1:0] alu_a_q, alu_a_d;
  logic [REG_W-1:0] alu_b_q, alu_b_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             we;
  logic [REG_W-1:0] ra_data, rb_data;

  toy_opcode_t opcode;
  logic        accept;

  assign opcode = toy_opcode_t'(io.instr_i[OPC_MSB:OPC_LSB]);
  // Ready is withheld during reset and on the cycle an illegal opcode retires.
  assign io.instr_ready_o = (state_q == S_IDLE) && !illegal_q && !rst_i;
  assign accept = io.instr_valid_i && io.instr_ready_o;

  core_regfile u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ra_addr_i  (io.instr_i[RS_MSB:RS_LSB]),
    .rb_addr_i  (io.instr_i[RT_MSB:RT_LSB]),
    .dbg_addr_i (dbg_addr_i),
    .ra_data_o  (ra_data),
    .rb_data_o  (rb_data),
    .dbg_data_o (dbg_data_o),
    .we_i       (we),
    .wr_addr_i  (rd_q),
    .wr_data_i  (io.alu_c_i)
  );

  // Sequencer next-state: decode on accept, then ISSUE -> WB -> IDLE.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    we        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_HLT) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else if (io.instr_i[OPC_MSB]) begin
            // Memory/branch class opcodes are retired as illegal here.
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end else begin
            rd_d     = io.instr_i[RD_MSB:RD_LSB];
            alu_op_d = alu_op_for(opcode);
            if (opcode == OP_LDA) begin
              alu_a_d = '0;
              alu_b_d = {8'h00, io.instr_i[ADDR_MSB:ADDR_LSB]};
            end else begin
              alu_a_d = ra_data;
              alu_b_d = rb_data;
            end
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // ALU samples the held operands at the end of this cycle.
        state_d = S_WB;
        done_d  = 1'b1;
      end
      S_WB: begin
        we      = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and ALU-bus registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign io.alu_op_o = alu_op_q;
  assign io.alu_a_o  = alu_a_q;
  assign io.alu_b_o  = alu_b_q;
  assign done_o      = done_q;
  assign illegal_o   = illegal_q;
  assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_core_alu_issue.sv
// Scoreboard bench for core_alu_issue: directed instructions, expected
// retirements queued at issue time and checked by an independent monitor.
module tb_core_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done, illegal, halted;
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_data;
  int          cyc = 0;
  int          napplied = 0;
  int          nmis = 0;

  typedef struct {
    int    cyc;
    bit    ill;
    bit    hlt;
    string nm;
  } exp_t;

  exp_t sbq[$];

  core_alu_issue_if io ();

  core_alu_issue #(.ALU_LAT(1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .io         (io),
    .done_o     (done),
    .illegal_o  (illegal),
    .halted_o   (halted),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU with one register stage between operands and result.
  always @(posedge clk) begin
    case (io.alu_op_o)
      3'd0:    io.alu_c_i <= io.alu_a_o + io.alu_b_o;
      3'd1:    io.alu_c_i <= io.alu_a_o - io.alu_b_o;
      3'd2:    io.alu_c_i <= io.alu_a_o & io.alu_b_o;
      3'd3:    io.alu_c_i <= io.alu_a_o ^ io.alu_b_o;
      3'd4:    io.alu_c_i <= io.alu_a_o << io.alu_b_o[3:0];
      3'd5:    io.alu_c_i <= io.alu_a_o >> io.alu_b_o[3:0];
      3'd6:    io.alu_c_i <= io.alu_a_o;
      default: io.alu_c_i <= io.alu_b_o;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    napplied++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.nm, "_done_cycle"}, cyc, e.cyc);
        check({e.nm, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        check({e.nm, "_halted"}, {31'd0, halted}, {31'd0, e.hlt});
      end
    end else if (illegal === 1'b1) begin
      check("illegal_without_done", 32'd1, 32'd0);
    end
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (io.instr_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // dly = clock edges from the accepting edge to the cycle done_o is high.
  task automatic issue(input logic [15:0] ins, input int dly, input bit ill,
                       input bit hlt, input bit exp_done, input string nm);
    bit ok;
    wait_ready(50, ok);
    check({nm, "_ready_before"}, {31'd0, ok}, 32'd1);
    io.instr_valid_i = 1'b1;
    io.instr_i       = ins;
    @(posedge clk);
    #1;
    io.instr_valid_i = 1'b0;
    if (exp_done) sbq.push_back('{cyc + dly, ill, hlt, nm});
  endtask

  task automatic chk_reg(input logic [3:0] a, input logic [15:0] v, input string nm);
    bit ok;
    wait_ready(50, ok);
    check({nm, "_ready_after"}, {31'd0, ok}, 32'd1);
    dbg_addr = a;
    #1;
    check(nm, {16'd0, dbg_data}, {16'd0, v});
  endtask

  task automatic chk_alu(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input string nm);
    check({nm, "_op"}, {29'd0, io.alu_op_o}, {29'd0, op});
    check({nm, "_a"}, {16'd0, io.alu_a_o}, {16'd0, a});
    check({nm, "_b"}, {16'd0, io.alu_b_o}, {16'd0, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.instr_valid_i = 1'b0;
    io.instr_i       = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, io.instr_ready_o}, 32'd0);
    chk_alu(3'd0, 16'h0000, 16'h0000, "rst_alu");
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, io.instr_ready_o}, 32'd1);

    // Loads and dependent ALU ops
    issue(16'h7105, 1, 1'b0, 1'b0, 1'b1, "lda_r1");
    chk_alu(3'd7, 16'h0000, 16'h0005, "lda_r1_issue");
    chk_reg(4'd1, 16'h0005, "r1");
    issue(16'h72FF, 1, 1'b0, 1'b0, 1'b1, "lda_r2");
    chk_reg(4'd2, 16'h00FF, "r2");
    issue(16'h1312, 1, 1'b0, 1'b0, 1'b1, "add_r3");
    chk_alu(3'd0, 16'h0005, 16'h00FF, "add_r3_issue");
    chk_reg(4'd3, 16'h0104, "r3");
    issue(16'h2412, 1, 1'b0, 1'b0, 1'b1, "sub_r4");
    chk_reg(4'd4, 16'hFF06, "r4");
    issue(16'h5511, 1, 1'b0, 1'b0, 1'b1, "shl_r5");
    chk_alu(3'd4, 16'h0005, 16'h0005, "shl_r5_issue");
    chk_reg(4'd5, 16'h00A0, "r5");

    // Write to R0 retires but is discarded
    issue(16'h7012, 1, 1'b0, 1'b0, 1'b1, "lda_r0");
    chk_reg(4'd0, 16'h0000, "r0");

    // Illegal opcode: one cycle of done/illegal with ready low
    issue(16'h8123, 0, 1'b1, 1'b0, 1'b1, "illegal_8");
    check("illegal_ready_low", {31'd0, io.instr_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    check("illegal_ready_back", {31'd0, io.instr_ready_o}, 32'd1);
    chk_reg(4'd1, 16'h0005, "ill_r1");
    chk_reg(4'd2, 16'h00FF, "ill_r2");
    chk_reg(4'd3, 16'h0104, "ill_r3");

    // Halt is absorbing
    issue(16'h0000, 0, 1'b0, 1'b1, 1'b1, "halt");
    check("halt_halted", {31'd0, halted}, 32'd1);
    io.instr_valid_i = 1'b1;
    io.instr_i       = 16'h1312;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("halt_ready_stuck", {31'd0, io.instr_ready_o}, 32'd0);
      check("halt_level", {31'd0, halted}, 32'd1);
    end
    io.instr_valid_i = 1'b0;

    // Reset clears halt; reload and abort an add mid-ISSUE
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    #1;
    issue(16'h7105, 1, 1'b0, 1'b0, 1'b1, "lda_r1_b");
    chk_reg(4'd1, 16'h0005, "r1_b");
    issue(16'h72FF, 1, 1'b0, 1'b0, 1'b1, "lda_r2_b");
    chk_reg(4'd2, 16'h00FF, "r2_b");
    issue(16'h1312, 1, 1'b0, 1'b0, 1'b0, "add_abort");
    chk_alu(3'd0, 16'h0005, 16'h00FF, "abort_issue");
    #2;
    rst = 1'b1;
    #1;
    chk_alu(3'd0, 16'h0000, 16'h0000, "abort_rst_alu");
    check("abort_rst_ready", {31'd0, io.instr_ready_o}, 32'd0);
    check("abort_rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reg(4'd3, 16'h0000, "abort_r3");
    chk_reg(4'd1, 16'h0000, "abort_r1");
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
    $finish;
  end

endmodule
